// File: rtl/mem_issue_queue_if.sv
// mem_issue_queue_if
//   Dispatch and execute side of the memory issue queue, grouped as one bus.
//   master : dispatch/execute logic (drives allocation requests and results)
//   slave  : the issue queue (answers with free-entry status and tail index)
//
//   Alloc_valid_IN / Alloc_ready_OUT   allocation handshake
//   Alloc_idx_OUT                      index the next allocation receives
//   Alloc_*_IN                         decoded fields of the memory instruction
//   Exec_valid_IN / Exec_idx_IN        result delivery, tagged by queue index
//   Exec_Address_IN / Exec_StoreData_IN effective address and store data
interface mem_issue_queue_if #(
   parameter int IDX_W = 2
);
   logic             Alloc_valid_IN;
   logic             Alloc_ready_OUT;
   logic [IDX_W-1:0] Alloc_idx_OUT;
   logic [31:0]      Alloc_Instr_IN;
   logic [31:0]      Alloc_PC_IN;
   logic [5:0]       Alloc_ALU_Control_IN;
   logic             Alloc_MemRead_IN;
   logic             Alloc_MemWrite_IN;
   logic [4:0]       Alloc_WriteRegister_IN;
   logic             Alloc_RegWrite_IN;
   logic             Exec_valid_IN;
   logic [IDX_W-1:0] Exec_idx_IN;
   logic [31:0]      Exec_Address_IN;
   logic [31:0]      Exec_StoreData_IN;

   modport master (
      output Alloc_valid_IN, Alloc_Instr_IN, Alloc_PC_IN, Alloc_ALU_Control_IN,
             Alloc_MemRead_IN, Alloc_MemWrite_IN, Alloc_WriteRegister_IN,
             Alloc_RegWrite_IN, Exec_valid_IN, Exec_idx_IN, Exec_Address_IN,
             Exec_StoreData_IN,
      input  Alloc_ready_OUT, Alloc_idx_OUT
   );

   modport slave (
      input  Alloc_valid_IN, Alloc_Instr_IN, Alloc_PC_IN, Alloc_ALU_Control_IN,
             Alloc_MemRead_IN, Alloc_MemWrite_IN, Alloc_WriteRegister_IN,
             Alloc_RegWrite_IN, Exec_valid_IN, Exec_idx_IN, Exec_Address_IN,
             Exec_StoreData_IN,
      output Alloc_ready_OUT, Alloc_idx_OUT
   );
endinterface

// File: rtl/mem_issue_queue.sv
// mem_issue_queue
//   In-order load/store issue queue feeding the MEM stage. Instructions are
//   allocated in program order; address and store data arrive later, out of
//   order, tagged by queue index. The oldest entry is issued once its operands
//   are present, one per cycle, into a registered MEM input bundle; a NOP
//   bubble (all zeros) is issued whenever the head is not ready.
//
//   CLK, RESET (async, active low), FLUSH (sync clear)
//   q_if      : dispatch/execute bus (slave side)
//   *1_OUT    : registered bundle to the MEM stage inputs
//   Count_OUT : number of occupied entries
module mem_issue_queue #(
   parameter int DEPTH = 4,
   parameter int IDX_W = 2
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               FLUSH,
   mem_issue_queue_if.slave   q_if,
   output logic [31:0]        Instr1_OUT,
   output logic [31:0]        Instr1_PC_OUT,
   output logic [31:0]        ALU_result1_OUT,
   output logic [31:0]        MemWriteData1_OUT,
   output logic [4:0]         WriteRegister1_OUT,
   output logic               RegWrite1_OUT,
   output logic [5:0]         ALU_Control1_OUT,
   output logic               MemRead1_OUT,
   output logic               MemWrite1_OUT,
   output logic [IDX_W:0]     Count_OUT
);

   localparam logic [IDX_W:0] FULL_COUNT = (IDX_W+1)'(DEPTH);

   logic             valid_q     [DEPTH];
   logic             ready_q     [DEPTH];
   logic [31:0]      instr_q     [DEPTH];
   logic [31:0]      pc_q        [DEPTH];
   logic [5:0]       alu_ctrl_q  [DEPTH];
   logic             mem_read_q  [DEPTH];
   logic             mem_write_q [DEPTH];
   logic [4:0]       wr_reg_q    [DEPTH];
   logic             reg_write_q [DEPTH];
   logic [31:0]      addr_q      [DEPTH];
   logic [31:0]      sdata_q     [DEPTH];

   logic [IDX_W-1:0] head_q;
   logic [IDX_W-1:0] tail_q;
   logic [IDX_W:0]   count_q;

   logic             alloc_ready;
   logic             alloc_fire;
   logic             issue_fire;
   logic             exec_hit;

   // Free-entry status comes from registered count only, so a full queue
   // refuses allocation even in a cycle where the head issues.
   assign alloc_ready          = (count_q != FULL_COUNT);
   assign q_if.Alloc_ready_OUT = alloc_ready;
   assign q_if.Alloc_idx_OUT   = tail_q;
   assign Count_OUT            = count_q;

   assign alloc_fire = q_if.Alloc_valid_IN && alloc_ready;
   assign issue_fire = valid_q[head_q] && ready_q[head_q];
   // An entry allocated on this same edge is still invalid, so an exec aimed
   // at it is dropped; already-ready entries keep their first result.
   assign exec_hit   = q_if.Exec_valid_IN && valid_q[q_if.Exec_idx_IN]
                       && !ready_q[q_if.Exec_idx_IN];

   // Control state and the MEM bundle. Exec only targets valid entries and
   // alloc only the invalid tail, so the per-entry writes never collide.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int i = 0; i < DEPTH; i++) begin
            valid_q[i] <= 1'b0;
            ready_q[i] <= 1'b0;
         end
         head_q             <= '0;
         tail_q             <= '0;
         count_q            <= '0;
         Instr1_OUT         <= '0;
         Instr1_PC_OUT      <= '0;
         ALU_result1_OUT    <= '0;
         MemWriteData1_OUT  <= '0;
         WriteRegister1_OUT <= '0;
         RegWrite1_OUT      <= 1'b0;
         ALU_Control1_OUT   <= '0;
         MemRead1_OUT       <= 1'b0;
         MemWrite1_OUT      <= 1'b0;
      end else if (FLUSH) begin
         for (int i = 0; i < DEPTH; i++) begin
            valid_q[i] <= 1'b0;
            ready_q[i] <= 1'b0;
         end
         head_q             <= '0;
         tail_q             <= '0;
         count_q            <= '0;
         Instr1_OUT         <= '0;
         Instr1_PC_OUT      <= '0;
         ALU_result1_OUT    <= '0;
         MemWriteData1_OUT  <= '0;
         WriteRegister1_OUT <= '0;
         RegWrite1_OUT      <= 1'b0;
         ALU_Control1_OUT   <= '0;
         MemRead1_OUT       <= 1'b0;
         MemWrite1_OUT      <= 1'b0;
      end else begin
         if (exec_hit) begin
            ready_q[q_if.Exec_idx_IN] <= 1'b1;
         end

         if (issue_fire) begin
            valid_q[head_q]    <= 1'b0;
            head_q             <= head_q + IDX_W'(1);
            Instr1_OUT         <= instr_q[head_q];
            Instr1_PC_OUT      <= pc_q[head_q];
            ALU_result1_OUT    <= addr_q[head_q];
            MemWriteData1_OUT  <= sdata_q[head_q];
            WriteRegister1_OUT <= wr_reg_q[head_q];
            RegWrite1_OUT      <= reg_write_q[head_q];
            ALU_Control1_OUT   <= alu_ctrl_q[head_q];
            MemRead1_OUT       <= mem_read_q[head_q];
            MemWrite1_OUT      <= mem_write_q[head_q];
         end else begin
            Instr1_OUT         <= '0;
            Instr1_PC_OUT      <= '0;
            ALU_result1_OUT    <= '0;
            MemWriteData1_OUT  <= '0;
            WriteRegister1_OUT <= '0;
            RegWrite1_OUT      <= 1'b0;
            ALU_Control1_OUT   <= '0;
            MemRead1_OUT       <= 1'b0;
            MemWrite1_OUT      <= 1'b0;
         end

         if (alloc_fire) begin
            valid_q[tail_q] <= 1'b1;
            ready_q[tail_q] <= 1'b0;
            tail_q          <= tail_q + IDX_W'(1);
         end

         case ({alloc_fire, issue_fire})
            2'b10:   count_q <= count_q + (IDX_W+1)'(1);
            2'b01:   count_q <= count_q - (IDX_W+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Entry payload needs no reset: nothing reads it unless the valid/ready
   // bits, which are reset, say so.
   always_ff @(posedge CLK) begin
      if (!FLUSH) begin
         if (alloc_fire) begin
            instr_q[tail_q]     <= q_if.Alloc_Instr_IN;
            pc_q[tail_q]        <= q_if.Alloc_PC_IN;
            alu_ctrl_q[tail_q]  <= q_if.Alloc_ALU_Control_IN;
            mem_read_q[tail_q]  <= q_if.Alloc_MemRead_IN;
            mem_write_q[tail_q] <= q_if.Alloc_MemWrite_IN;
            wr_reg_q[tail_q]    <= q_if.Alloc_WriteRegister_IN;
            reg_write_q[tail_q] <= q_if.Alloc_RegWrite_IN;
         end
         if (exec_hit) begin
            addr_q[q_if.Exec_idx_IN]  <= q_if.Exec_Address_IN;
            sdata_q[q_if.Exec_idx_IN] <= q_if.Exec_StoreData_IN;
         end
      end
   end

endmodule

// File: tb/tb_mem_issue_queue.sv
// tb_mem_issue_queue
//   Self-checking bench for mem_issue_queue. Directed scenarios use constant
//   expectations; the random scenario compares against a program-order queue
//   model of the issue rules.
module tb_mem_issue_queue;

   localparam int DEPTH = 4;
   localparam int IDX_W = 2;

   localparam logic [5:0] ALU_LW = 6'b111101;
   localparam logic [5:0] ALU_SW = 6'b111110;

   logic CLK   = 1'b0;
   logic RESET = 1'b0;
   logic FLUSH = 1'b0;

   logic [31:0]    Instr1_OUT;
   logic [31:0]    Instr1_PC_OUT;
   logic [31:0]    ALU_result1_OUT;
   logic [31:0]    MemWriteData1_OUT;
   logic [4:0]     WriteRegister1_OUT;
   logic           RegWrite1_OUT;
   logic [5:0]     ALU_Control1_OUT;
   logic           MemRead1_OUT;
   logic           MemWrite1_OUT;
   logic [IDX_W:0] Count_OUT;

   int checks = 0;
   int errors = 0;

   mem_issue_queue_if #(.IDX_W(IDX_W)) q_if ();

   mem_issue_queue #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
      .CLK                (CLK),
      .RESET              (RESET),
      .FLUSH              (FLUSH),
      .q_if               (q_if),
      .Instr1_OUT         (Instr1_OUT),
      .Instr1_PC_OUT      (Instr1_PC_OUT),
      .ALU_result1_OUT    (ALU_result1_OUT),
      .MemWriteData1_OUT  (MemWriteData1_OUT),
      .WriteRegister1_OUT (WriteRegister1_OUT),
      .RegWrite1_OUT      (RegWrite1_OUT),
      .ALU_Control1_OUT   (ALU_Control1_OUT),
      .MemRead1_OUT       (MemRead1_OUT),
      .MemWrite1_OUT      (MemWrite1_OUT),
      .Count_OUT          (Count_OUT)
   );

   always #5 CLK = ~CLK;

   // Reference model: occupied entries in program order, oldest first.
   typedef struct {
      int          idx;
      logic [31:0] instr;
      logic [31:0] pc;
      logic [5:0]  alu;
      logic        mr;
      logic        mw;
      logic [4:0]  wreg;
      logic        rw;
      bit          ready;
      logic [31:0] addr;
      logic [31:0] sdata;
   } ent_t;

   ent_t         mq[$];
   int           m_tail = 0;
   logic [141:0] exp_bundle = '0;

   function automatic logic [141:0] dut_bundle();
      return {Instr1_OUT, Instr1_PC_OUT, ALU_result1_OUT, MemWriteData1_OUT,
              WriteRegister1_OUT, RegWrite1_OUT, ALU_Control1_OUT,
              MemRead1_OUT, MemWrite1_OUT};
   endfunction

   task automatic model_clear();
      mq.delete();
      m_tail     = 0;
      exp_bundle = '0;
   endtask

   // Apply one clock edge's worth of rules to the model using current inputs.
   task automatic model_edge();
      bit   full;
      bit   issue;
      ent_t e;
      if (FLUSH) begin
         model_clear();
         return;
      end
      full  = (mq.size() == DEPTH);
      issue = (mq.size() > 0) && mq[0].ready;
      if (q_if.Exec_valid_IN) begin
         foreach (mq[i]) begin
            if (mq[i].idx == int'(q_if.Exec_idx_IN) && !mq[i].ready) begin
               mq[i].ready = 1'b1;
               mq[i].addr  = q_if.Exec_Address_IN;
               mq[i].sdata = q_if.Exec_StoreData_IN;
            end
         end
      end
      if (issue) begin
         e = mq.pop_front();
         exp_bundle = {e.instr, e.pc, e.addr, e.sdata, e.wreg, e.rw, e.alu,
                       e.mr, e.mw};
      end else begin
         exp_bundle = '0;
      end
      if (q_if.Alloc_valid_IN && !full) begin
         e.idx   = m_tail;
         e.instr = q_if.Alloc_Instr_IN;
         e.pc    = q_if.Alloc_PC_IN;
         e.alu   = q_if.Alloc_ALU_Control_IN;
         e.mr    = q_if.Alloc_MemRead_IN;
         e.mw    = q_if.Alloc_MemWrite_IN;
         e.wreg  = q_if.Alloc_WriteRegister_IN;
         e.rw    = q_if.Alloc_RegWrite_IN;
         e.ready = 1'b0;
         e.addr  = '0;
         e.sdata = '0;
         mq.push_back(e);
         m_tail = (m_tail + 1) % DEPTH;
      end
   endtask

   task automatic cycle();
      model_edge();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      q_if.Alloc_valid_IN = 1'b0;
      q_if.Exec_valid_IN  = 1'b0;
      FLUSH               = 1'b0;
   endtask

   task automatic set_alloc(input logic [31:0] instr, input logic [5:0] alu,
                            input logic mr, input logic mw,
                            input logic [4:0] wreg, input logic rw);
      q_if.Alloc_valid_IN         = 1'b1;
      q_if.Alloc_Instr_IN         = instr;
      q_if.Alloc_PC_IN            = 32'h0040_0000 + {instr[29:0], 2'b00};
      q_if.Alloc_ALU_Control_IN   = alu;
      q_if.Alloc_MemRead_IN       = mr;
      q_if.Alloc_MemWrite_IN      = mw;
      q_if.Alloc_WriteRegister_IN = wreg;
      q_if.Alloc_RegWrite_IN      = rw;
   endtask

   task automatic set_exec(input int idx, input logic [31:0] addr,
                           input logic [31:0] sdata);
      q_if.Exec_valid_IN     = 1'b1;
      q_if.Exec_idx_IN       = IDX_W'(idx);
      q_if.Exec_Address_IN   = addr;
      q_if.Exec_StoreData_IN = sdata;
   endtask

   task automatic do_flush();
      idle();
      FLUSH = 1'b1;
      cycle();
      FLUSH = 1'b0;
   endtask

   task automatic test_reset();
      RESET = 1'b0;
      q_if.Alloc_valid_IN = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      model_clear();
      checks++;
      if (Count_OUT !== '0) begin
         errors++;
         $display("[TB] FAIL reset_count: got %0d expected 0", Count_OUT);
      end
      checks++;
      if (q_if.Alloc_ready_OUT !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_ready: got %b expected 1", q_if.Alloc_ready_OUT);
      end
      checks++;
      if (q_if.Alloc_idx_OUT !== '0) begin
         errors++;
         $display("[TB] FAIL reset_idx: got %0d expected 0", q_if.Alloc_idx_OUT);
      end
      checks++;
      if (dut_bundle() !== '0) begin
         errors++;
         $display("[TB] FAIL reset_bundle: got %h expected 0", dut_bundle());
      end
      idle();
      #2 RESET = 1'b1;
      #1;
      set_alloc(32'h0000_00A5, ALU_LW, 1'b1, 1'b0, 5'd3, 1'b1);
      checks++;
      if (q_if.Alloc_idx_OUT !== 2'd0) begin
         errors++;
         $display("[TB] FAIL first_alloc_idx: got %0d expected 0", q_if.Alloc_idx_OUT);
      end
      cycle();
      idle();
      checks++;
      if (Count_OUT !== 3'd1 || q_if.Alloc_idx_OUT !== 2'd1) begin
         errors++;
         $display("[TB] FAIL first_alloc_taken: got count %0d idx %0d expected 1 1",
                  Count_OUT, q_if.Alloc_idx_OUT);
      end
   endtask

   task automatic test_single_load();
      do_flush();
      set_alloc(32'h8C05_0000, ALU_LW, 1'b1, 1'b0, 5'd5, 1'b1);
      cycle();
      idle();
      checks++;
      if (Count_OUT !== 3'd1) begin
         errors++;
         $display("[TB] FAIL load_count_alloc: got %0d expected 1", Count_OUT);
      end
      set_exec(0, 32'h0000_0100, 32'h0);
      cycle();
      idle();
      checks++;
      if (dut_bundle() !== '0) begin
         errors++;
         $display("[TB] FAIL load_no_bypass: got %h expected 0", dut_bundle());
      end
      cycle();
      checks++;
      if (ALU_result1_OUT !== 32'h100 || MemRead1_OUT !== 1'b1 ||
          WriteRegister1_OUT !== 5'd5 || ALU_Control1_OUT !== ALU_LW ||
          Instr1_OUT !== 32'h8C05_0000 || RegWrite1_OUT !== 1'b1) begin
         errors++;
         $display("[TB] FAIL load_issue: got addr %h rd %b reg %0d alu %b expected 100 1 5 %b",
                  ALU_result1_OUT, MemRead1_OUT, WriteRegister1_OUT, ALU_Control1_OUT, ALU_LW);
      end
      cycle();
      checks++;
      if (dut_bundle() !== '0 || Count_OUT !== '0) begin
         errors++;
         $display("[TB] FAIL load_bubble_after: got bundle %h count %0d expected 0 0",
                  dut_bundle(), Count_OUT);
      end
   endtask

   task automatic test_out_of_order();
      do_flush();
      set_alloc(32'hA0, ALU_SW, 1'b0, 1'b1, 5'd0, 1'b0);
      cycle();
      set_alloc(32'hA1, ALU_LW, 1'b1, 1'b0, 5'd8, 1'b1);
      cycle();
      set_alloc(32'hA2, ALU_LW, 1'b1, 1'b0, 5'd9, 1'b1);
      cycle();
      idle();
      for (int k = 2; k >= 0; k--) begin
         set_exec(k, 32'h200 + 32'(k) * 32'h10, (k == 0) ? 32'hDEAD_BEEF : 32'h0);
         cycle();
         idle();
         checks++;
         if (dut_bundle() !== '0 || Count_OUT !== 3'd3) begin
            errors++;
            $display("[TB] FAIL ooo_wait_%0d: got bundle %h count %0d expected 0 3",
                     k, dut_bundle(), Count_OUT);
         end
      end
      cycle();
      checks++;
      if (Instr1_OUT !== 32'hA0 || ALU_result1_OUT !== 32'h200 ||
          MemWriteData1_OUT !== 32'hDEAD_BEEF || MemWrite1_OUT !== 1'b1 ||
          MemRead1_OUT !== 1'b0) begin
         errors++;
         $display("[TB] FAIL ooo_issue0: got instr %h addr %h wdata %h wr %b expected a0 200 deadbeef 1",
                  Instr1_OUT, ALU_result1_OUT, MemWriteData1_OUT, MemWrite1_OUT);
      end
      for (int k = 1; k <= 2; k++) begin
         cycle();
         checks++;
         if (Instr1_OUT !== 32'hA0 + 32'(k) ||
             ALU_result1_OUT !== 32'h200 + 32'(k) * 32'h10 || MemRead1_OUT !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ooo_issue%0d: got instr %h addr %h expected %h %h",
                     k, Instr1_OUT, ALU_result1_OUT, 32'hA0 + 32'(k), 32'h200 + 32'(k) * 32'h10);
         end
      end
      checks++;
      if (Count_OUT !== '0) begin
         errors++;
         $display("[TB] FAIL ooo_drained: got %0d expected 0", Count_OUT);
      end
   endtask

   task automatic test_full_wrap();
      do_flush();
      for (int k = 0; k < DEPTH; k++) begin
         set_alloc(32'hC0 + 32'(k), ALU_LW, 1'b1, 1'b0, 5'(k + 1), 1'b1);
         cycle();
      end
      idle();
      checks++;
      if (Count_OUT !== 3'd4 || q_if.Alloc_ready_OUT !== 1'b0 || q_if.Alloc_idx_OUT !== 2'd0) begin
         errors++;
         $display("[TB] FAIL full_state: got count %0d ready %b idx %0d expected 4 0 0",
                  Count_OUT, q_if.Alloc_ready_OUT, q_if.Alloc_idx_OUT);
      end
      set_alloc(32'hCF, ALU_LW, 1'b1, 1'b0, 5'd31, 1'b1);
      set_exec(0, 32'h400, 32'h0);
      cycle();
      q_if.Exec_valid_IN = 1'b0;
      checks++;
      if (Count_OUT !== 3'd4 || dut_bundle() !== '0) begin
         errors++;
         $display("[TB] FAIL full_refuse: got count %0d bundle %h expected 4 0",
                  Count_OUT, dut_bundle());
      end
      cycle();
      idle();
      checks++;
      if (Instr1_OUT !== 32'hC0 || Count_OUT !== 3'd3 ||
          q_if.Alloc_idx_OUT !== 2'd0 || q_if.Alloc_ready_OUT !== 1'b1) begin
         errors++;
         $display("[TB] FAIL full_issue_no_bypass: got instr %h count %0d idx %0d expected c0 3 0",
                  Instr1_OUT, Count_OUT, q_if.Alloc_idx_OUT);
      end
      set_alloc(32'hC4, ALU_LW, 1'b1, 1'b0, 5'd7, 1'b1);
      cycle();
      idle();
      checks++;
      if (Count_OUT !== 3'd4 || q_if.Alloc_idx_OUT !== 2'd1) begin
         errors++;
         $display("[TB] FAIL wrap_alloc: got count %0d idx %0d expected 4 1",
                  Count_OUT, q_if.Alloc_idx_OUT);
      end
   endtask

   task automatic test_simultaneous();
      do_flush();
      set_alloc(32'hB0, ALU_LW, 1'b1, 1'b0, 5'd1, 1'b1);
      cycle();
      set_alloc(32'hB1, ALU_LW, 1'b1, 1'b0, 5'd2, 1'b1);
      set_exec(0, 32'h300, 32'h0);
      cycle();
      checks++;
      if (Count_OUT !== 3'd2 || dut_bundle() !== '0) begin
         errors++;
         $display("[TB] FAIL sim_alloc_exec: got count %0d bundle %h expected 2 0",
                  Count_OUT, dut_bundle());
      end
      set_alloc(32'hB2, ALU_LW, 1'b1, 1'b0, 5'd3, 1'b1);
      set_exec(3, 32'hBAD, 32'h0);
      cycle();
      idle();
      checks++;
      if (Count_OUT !== 3'd2 || Instr1_OUT !== 32'hB0 || ALU_result1_OUT !== 32'h300) begin
         errors++;
         $display("[TB] FAIL sim_alloc_issue: got count %0d instr %h addr %h expected 2 b0 300",
                  Count_OUT, Instr1_OUT, ALU_result1_OUT);
      end
      set_exec(1, 32'h310, 32'h0);
      cycle();
      set_exec(1, 32'h999, 32'h0);
      cycle();
      idle();
      checks++;
      if (Instr1_OUT !== 32'hB1 || ALU_result1_OUT !== 32'h310 || Count_OUT !== 3'd1) begin
         errors++;
         $display("[TB] FAIL sim_second_exec: got instr %h addr %h count %0d expected b1 310 1",
                  Instr1_OUT, ALU_result1_OUT, Count_OUT);
      end
      set_exec(2, 32'h320, 32'h0);
      cycle();
      idle();
      cycle();
      checks++;
      if (Instr1_OUT !== 32'hB2 || ALU_result1_OUT !== 32'h320 || Count_OUT !== '0) begin
         errors++;
         $display("[TB] FAIL sim_issue_c: got instr %h addr %h count %0d expected b2 320 0",
                  Instr1_OUT, ALU_result1_OUT, Count_OUT);
      end
      set_alloc(32'hB3, ALU_LW, 1'b1, 1'b0, 5'd4, 1'b1);
      cycle();
      idle();
      repeat (2) cycle();
      checks++;
      if (dut_bundle() !== '0 || Count_OUT !== 3'd1) begin
         errors++;
         $display("[TB] FAIL sim_stale_exec: got bundle %h count %0d expected 0 1",
                  dut_bundle(), Count_OUT);
      end
   endtask

   task automatic test_flush();
      do_flush();
      for (int k = 0; k < 3; k++) begin
         set_alloc(32'hD0 + 32'(k), ALU_LW, 1'b1, 1'b0, 5'(k + 10), 1'b1);
         cycle();
      end
      idle();
      set_exec(0, 32'h500, 32'h0);
      cycle();
      set_alloc(32'hDF, ALU_LW, 1'b1, 1'b0, 5'd20, 1'b1);
      set_exec(1, 32'h510, 32'h0);
      FLUSH = 1'b1;
      cycle();
      idle();
      checks++;
      if (Count_OUT !== '0 || dut_bundle() !== '0 || q_if.Alloc_idx_OUT !== '0) begin
         errors++;
         $display("[TB] FAIL flush_state: got count %0d bundle %h idx %0d expected 0 0 0",
                  Count_OUT, dut_bundle(), q_if.Alloc_idx_OUT);
      end
      repeat (3) cycle();
      checks++;
      if (Count_OUT !== '0 || dut_bundle() !== '0) begin
         errors++;
         $display("[TB] FAIL flush_quiet: got count %0d bundle %h expected 0 0",
                  Count_OUT, dut_bundle());
      end
   endtask

   task automatic test_random();
      do_flush();
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 99) < 55) begin
            set_alloc($urandom, 6'($urandom), 1'($urandom), 1'($urandom),
                      5'($urandom), 1'($urandom));
            q_if.Alloc_PC_IN = $urandom;
         end else begin
            q_if.Alloc_valid_IN = 1'b0;
         end
         if ($urandom_range(0, 99) < 60)
            set_exec($urandom_range(0, DEPTH - 1), $urandom, $urandom);
         else
            q_if.Exec_valid_IN = 1'b0;
         FLUSH = ($urandom_range(0, 99) < 3);
         cycle();
         checks++;
         if (Count_OUT !== (IDX_W+1)'(mq.size()) ||
             q_if.Alloc_idx_OUT !== IDX_W'(m_tail) ||
             q_if.Alloc_ready_OUT !== (mq.size() != DEPTH)) begin
            errors++;
            $display("[TB] FAIL rand_state_%0d: got count %0d idx %0d ready %b expected %0d %0d %b",
                     n, Count_OUT, q_if.Alloc_idx_OUT, q_if.Alloc_ready_OUT,
                     mq.size(), m_tail, mq.size() != DEPTH);
         end
         checks++;
         if (dut_bundle() !== exp_bundle) begin
            errors++;
            $display("[TB] FAIL rand_bundle_%0d: got %h expected %h", n, dut_bundle(), exp_bundle);
         end
      end
      idle();
      set_alloc(32'hE0, ALU_LW, 1'b1, 1'b0, 5'd1, 1'b1);
      cycle();
      idle();
      #3 RESET = 1'b0;
      #1;
      model_clear();
      checks++;
      if (Count_OUT !== '0 || dut_bundle() !== '0 || q_if.Alloc_ready_OUT !== 1'b1) begin
         errors++;
         $display("[TB] FAIL mid_reset: got count %0d bundle %h ready %b expected 0 0 1",
                  Count_OUT, dut_bundle(), q_if.Alloc_ready_OUT);
      end
      #2 RESET = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      q_if.Alloc_valid_IN         = 1'b0;
      q_if.Alloc_Instr_IN         = '0;
      q_if.Alloc_PC_IN            = '0;
      q_if.Alloc_ALU_Control_IN   = '0;
      q_if.Alloc_MemRead_IN       = 1'b0;
      q_if.Alloc_MemWrite_IN      = 1'b0;
      q_if.Alloc_WriteRegister_IN = '0;
      q_if.Alloc_RegWrite_IN      = 1'b0;
      q_if.Exec_valid_IN          = 1'b0;
      q_if.Exec_idx_IN            = '0;
      q_if.Exec_Address_IN        = '0;
      q_if.Exec_StoreData_IN      = '0;
      test_reset();
      test_single_load();
      test_out_of_order();
      test_full_wrap();
      test_simultaneous();
      test_flush();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
